// File: rtl/neo_sample_buffer_if.sv
// neo_sample_buffer_if: producer/consumer handshake bundle for neo_sample_buffer.
// The slave modport is the buffer side; the master modport is the side that
// produces samples and consumes windows.
interface neo_sample_buffer_if #(
  parameter int N = 16
);
  logic                in_valid;
  logic signed [N-1:0] in_data;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_prev;
  logic signed [N-1:0] out_cur;
  logic signed [N-1:0] out_next;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_prev,
    output out_cur,
    output out_next
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_prev,
    input  out_cur,
    input  out_next
  );
endinterface

// File: rtl/neo_sample_buffer.sv
// neo_sample_buffer: circular store of M signed N-bit samples presenting a
// sliding 3-sample window (x[n-1], x[n], x[n+1]). Each pop advances the window
// by one sample. Samples pass through bit-exact.
// Optional feature: define NEO_BUF_DROP_CNT_EN to add drop_cnt[15:0], a
// saturating count of cycles where a sample was offered while full.
module neo_sample_buffer #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                flush,
  neo_sample_buffer_if.slave  sb,
  output logic [$clog2(M):0]  count,
  output logic                full,
  output logic                empty
`ifdef NEO_BUF_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int          AW    = $clog2(M);
  localparam int          CW    = AW + 1;
  localparam int unsigned DEPTH = M;

  logic signed [N-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_rp;
  logic [CW-1:0]       r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_valid;
  logic                w_push;
  logic                w_pop;
  logic [AW-1:0]       w_rp1;
  logic [AW-1:0]       w_rp2;

  assign w_full  = (r_count == CW'(M));
  assign w_empty = (r_count == '0);
  assign w_valid = (r_count >= CW'(3));
  assign w_push  = sb.in_valid && !w_full;
  assign w_pop   = w_valid && sb.out_ready;

  // Pointer arithmetic truncates to AW bits, so window indices wrap modulo M.
  assign w_rp1 = r_rp + AW'(1);
  assign w_rp2 = r_rp + AW'(2);

  // Sample storage: cleared on reset, written on an accepted push unless flushing.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!flush && w_push) begin
      r_mem[r_wp] <= sb.in_data;
    end
  end

  // Write pointer: flush rewinds, push advances.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_wp <= '0;
    end else if (flush) begin
      r_wp <= '0;
    end else if (w_push) begin
      r_wp <= r_wp + AW'(1);
    end
  end

  // Read pointer: each pop slides the window by exactly one sample.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_rp <= '0;
    end else if (flush) begin
      r_rp <= '0;
    end else if (w_pop) begin
      r_rp <= w_rp1;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef NEO_BUF_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Rejected-offer counter, saturating; flush clears it ahead of any increment.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_drop_cnt <= '0;
    end else if (sb.in_valid && w_full && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign sb.in_ready  = !w_full;
  assign sb.out_valid = w_valid;

  // With no valid window the outputs sit at zero: stable, never X.
  assign sb.out_prev  = w_valid ? r_mem[r_rp]  : '0;
  assign sb.out_cur   = w_valid ? r_mem[w_rp1] : '0;
  assign sb.out_next  = w_valid ? r_mem[w_rp2] : '0;

endmodule

// File: tb/tb_neo_sample_buffer.sv
// Testbench for neo_sample_buffer (N=16, M=16): directed table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_neo_sample_buffer;

  localparam int N = 16;
  localparam int M = 16;

  logic              Clk;
  logic              reset;
  logic              flush;
  logic [$clog2(M):0] count;
  logic              full;
  logic              empty;
`ifdef NEO_BUF_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  neo_sample_buffer_if #(.N(N)) bus_if ();

  neo_sample_buffer #(.N(N), .M(M)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .flush    (flush),
    .sb       (bus_if),
    .count    (count),
    .full     (full),
    .empty    (empty)
`ifdef NEO_BUF_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the buffer contents as an ordered queue of samples.
  logic signed [N-1:0] mq[$];
  int                  mdrop = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input int ecnt, input logic ev,
                           input logic signed [N-1:0] ep, input logic signed [N-1:0] ec,
                           input logic signed [N-1:0] en);
    chk({nm, "_count"}, 64'(count), 64'(ecnt));
    chk({nm, "_empty"}, 64'(empty), 64'(ecnt == 0));
    chk({nm, "_full"}, 64'(full), 64'(ecnt == M));
    chk({nm, "_in_ready"}, 64'(bus_if.in_ready), 64'(ecnt != M));
    chk({nm, "_out_valid"}, 64'(bus_if.out_valid), 64'(ev));
    if (ev) begin
      chk({nm, "_prev"}, 64'(bus_if.out_prev), 64'(ep));
      chk({nm, "_cur"}, 64'(bus_if.out_cur), 64'(ec));
      chk({nm, "_next"}, 64'(bus_if.out_next), 64'(en));
    end else begin
      chk({nm, "_window_known"},
          64'($isunknown({bus_if.out_prev, bus_if.out_cur, bus_if.out_next})), 64'(0));
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_count"}, 64'(count), 64'(0));
    chk({nm, "_empty"}, 64'(empty), 64'(1));
    chk({nm, "_full"}, 64'(full), 64'(0));
    chk({nm, "_in_ready"}, 64'(bus_if.in_ready), 64'(1));
    chk({nm, "_out_valid"}, 64'(bus_if.out_valid), 64'(0));
    chk({nm, "_prev"}, 64'(bus_if.out_prev), 64'(0));
    chk({nm, "_cur"}, 64'(bus_if.out_cur), 64'(0));
    chk({nm, "_next"}, 64'(bus_if.out_next), 64'(0));
`ifdef NEO_BUF_DROP_CNT_EN
    chk({nm, "_drop"}, 64'(drop_cnt), 64'(0));
`endif
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Apply one cycle of stimulus and advance the model by the same rules.
  task automatic drive(input logic f, input logic iv, input logic signed [N-1:0] d, input logic ordy);
    bit do_push;
    bit do_pop;
    flush            = f;
    bus_if.in_valid  = iv;
    bus_if.in_data   = d;
    bus_if.out_ready = ordy;
    if (f) begin
      mq.delete();
      mdrop = 0;
    end else begin
      do_push = iv && (mq.size() < M);
      do_pop  = ordy && (mq.size() >= 3);
      if (iv && mq.size() == M && mdrop < 65535) mdrop++;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
    tick();
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    flush            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    mq.delete();
    mdrop = 0;
    tick();
    chk_reset_outputs("reset");
    #2;
    reset = 1'b0;
    @(negedge Clk);
    #4;
  endtask

  typedef struct {
    logic                fl;
    logic                iv;
    logic signed [N-1:0] d;
    logic                ordy;
    int                  ecnt;
    logic                ev;
    logic signed [N-1:0] ep;
    logic signed [N-1:0] ec;
    logic signed [N-1:0] en;
  } vec_t;

  vec_t vt[$];

  initial begin
    int                  sz;
    logic signed [N-1:0] ep;
    logic signed [N-1:0] ec;
    logic signed [N-1:0] en;

    // Directed window sequence: fill, slide, extreme values, flush.
    vt.push_back('{1'b0, 1'b1,  16'sd5,     1'b0, 1, 1'b0, 16'sd0,  16'sd0,      16'sd0});
    vt.push_back('{1'b0, 1'b1, -16'sd3,     1'b0, 2, 1'b0, 16'sd0,  16'sd0,      16'sd0});
    vt.push_back('{1'b0, 1'b1,  16'sd7,     1'b0, 3, 1'b1, 16'sd5, -16'sd3,      16'sd7});
    vt.push_back('{1'b0, 1'b1,  16'sd2,     1'b1, 3, 1'b1, -16'sd3, 16'sd7,      16'sd2});
    vt.push_back('{1'b0, 1'b0,  16'sd0,     1'b1, 2, 1'b0, 16'sd0,  16'sd0,      16'sd0});
    vt.push_back('{1'b0, 1'b1,  16'sd9,     1'b0, 3, 1'b1, 16'sd7,  16'sd2,      16'sd9});
    vt.push_back('{1'b0, 1'b1, -16'sd32768, 1'b1, 3, 1'b1, 16'sd2,  16'sd9,     -16'sd32768});
    vt.push_back('{1'b0, 1'b1,  16'sd32767, 1'b0, 4, 1'b1, 16'sd2,  16'sd9,     -16'sd32768});
    vt.push_back('{1'b0, 1'b0,  16'sd0,     1'b1, 3, 1'b1, 16'sd9, -16'sd32768,  16'sd32767});
    vt.push_back('{1'b1, 1'b1,  16'sd4,     1'b1, 0, 1'b0, 16'sd0,  16'sd0,      16'sd0});

    do_reset();
    foreach (vt[i]) begin
      drive(vt[i].fl, vt[i].iv, vt[i].d, vt[i].ordy);
      chk_state($sformatf("vec%0d", i), vt[i].ecnt, vt[i].ev, vt[i].ep, vt[i].ec, vt[i].en);
    end

    // Fill to capacity, then offer one more sample that must be dropped.
    do_reset();
    for (int k = 0; k < M; k++) drive(1'b0, 1'b1, 16'(k * 7 - 50), 1'b0);
    chk_state("full16", M, 1'b1, -16'sd50, -16'sd43, -16'sd36);
    drive(1'b0, 1'b1, 16'sd1234, 1'b0);
    chk_state("full17", M, 1'b1, -16'sd50, -16'sd43, -16'sd36);
`ifdef NEO_BUF_DROP_CNT_EN
    chk("full17_drop", 64'(drop_cnt), 64'(1));
`endif
    for (int k = 0; k < M - 2; k++) drive(1'b0, 1'b0, '0, 1'b1);
    chk_state("drain", 2, 1'b0, '0, '0, '0);

    // Slide the window across the wrap point: read pointer ends at M-1.
    do_reset();
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 16'(100 + k), 1'b0);
    for (int k = 3; k < 18; k++) begin
      drive(1'b0, 1'b1, 16'(100 + k), 1'b1);
      chk_state($sformatf("wrap%0d", k), 3, 1'b1, 16'(100 + k - 2), 16'(100 + k - 1), 16'(100 + k));
    end

    // Flush together with push and pop at count 6.
    do_reset();
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 16'(10 + k), 1'b0);
    chk_state("preflush", 6, 1'b1, 16'sd10, 16'sd11, 16'sd12);
    drive(1'b1, 1'b1, 16'sd99, 1'b1);
    chk_state("flush", 0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 16'(40 + k), 1'b0);
    chk_state("postflush", 3, 1'b1, 16'sd40, 16'sd41, 16'sd42);

    // Asynchronous reset in mid-stream, with a push pending across it.
    do_reset();
    for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, 16'(-20 + k), 1'b0);
    chk_state("prereset", 9, 1'b1, -16'sd20, -16'sd19, -16'sd18);
    #2;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 16'sd77;
    bus_if.out_ready = 1'b1;
    reset            = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    tick();
    chk_reset_outputs("held_reset");
    #2;
    reset = 1'b0;
    mq.delete();
    mdrop = 0;
    drive(1'b0, 1'b1, 16'sd77, 1'b0);
    chk_state("first_push", 1, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 16'sd78, 1'b0);
    drive(1'b0, 1'b1, 16'sd79, 1'b0);
    chk_state("after_reset", 3, 1'b1, 16'sd77, 16'sd78, 16'sd79);

    // Randomized traffic against the queue model, with phases biased toward
    // filling and toward draining.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int  bias;
      bias = ((i / 100) % 2 == 0) ? 15 : 85;
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) >= 20),
            16'($urandom), ($urandom_range(0, 99) < bias));
      sz = mq.size();
      ep = (sz >= 3) ? mq[0] : '0;
      ec = (sz >= 3) ? mq[1] : '0;
      en = (sz >= 3) ? mq[2] : '0;
      chk_state($sformatf("rnd%0d", i), sz, (sz >= 3), ep, ec, en);
`ifdef NEO_BUF_DROP_CNT_EN
      chk($sformatf("rnd%0d_drop", i), 64'(drop_cnt), 64'(mdrop));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
